// File: rtl/io_event_reader_if.sv
// Bus between the gamepad IO interface / PIO bridge side and the event reader.
// Inputs are levels; each rising edge of irq, pop or clr_ovf is one event.
interface io_event_reader_if #(
  parameter int DEPTH = 8,
  parameter int DW    = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          irq;
  logic [DW-1:0] readdata;
  logic          pop;
  logic          clr_ovf;
  logic          irq_en;
  logic [DW-1:0] dout;
  logic          valid;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          host_irq;

  modport master (
    output irq, readdata, pop, clr_ovf, irq_en,
    input  dout, valid, full, count, overflow, host_irq
  );

  modport slave (
    input  irq, readdata, pop, clr_ovf, irq_en,
    output dout, valid, full, count, overflow, host_irq
  );
endinterface

// File: rtl/io_event_reader.sv
// Snapshots readdata on every irq rising edge into a show-ahead FIFO that the
// processor drains with edge-detected pop / clr_ovf levels.
module io_event_reader #(
  parameter int DEPTH = 8,
  parameter int DW    = 64
) (
  input logic              clk,
  input logic              rst_n,
  io_event_reader_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_r, count_next;
  logic          overflow_r, host_irq_r;
  logic          irq_q, pop_q, clr_q;

  logic push, pop_ev, clr_ev;
  logic is_empty, is_full;
  logic do_push, do_pop, drop;

  // Event semantics: a level high for any number of cycles is one event; the
  // input must return low for at least one cycle before it can fire again.
  assign push   = bus.irq & ~irq_q;
  assign pop_ev = bus.pop & ~pop_q;
  assign clr_ev = bus.clr_ovf & ~clr_q;

  assign is_empty = (count_r == '0);
  assign is_full  = (count_r == CW'(DEPTH));

  // Emptiness/fullness are judged before the edge; a pop on a full FIFO
  // frees the slot the simultaneous push lands in.
  assign do_pop  = pop_ev & ~is_empty;
  assign do_push = push & (~is_full | do_pop);
  assign drop    = push & is_full & ~do_pop;

  always_comb begin
    count_next = count_r;
    if (do_push & ~do_pop)      count_next = count_r + CW'(1);
    else if (do_pop & ~do_push) count_next = count_r - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      host_irq_r <= 1'b0;
      irq_q      <= 1'b0;
      pop_q      <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      irq_q   <= bus.irq;
      pop_q   <= bus.pop;
      clr_q   <= bus.clr_ovf;
      count_r <= count_next;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)        overflow_r <= 1'b1;
      else if (clr_ev) overflow_r <= 1'b0;
      host_irq_r <= ~is_empty & bus.irq_en;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= bus.readdata;
  end

  assign bus.dout     = is_empty ? '0 : mem[rd_ptr];
  assign bus.valid    = ~is_empty;
  assign bus.full     = is_full;
  assign bus.count    = count_r;
  assign bus.overflow = overflow_r;
  assign bus.host_irq = host_irq_r;
endmodule

// File: tb/tb_io_event_reader.sv
// Directed bench for io_event_reader: capture, ordering, overflow,
// simultaneous push/pop, pointer wrap, async reset and level-hold behaviour.
module tb_io_event_reader;
  localparam int DEPTH = 8;
  localparam int DW    = 64;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  io_event_reader_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

  io_event_reader #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic push_ev(input logic [DW-1:0] val);
    bus.readdata = val;
    bus.irq      = 1'b1;
    tick();
    bus.irq      = 1'b0;
    tick();
  endtask

  task automatic pop_pulse();
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    tick();
  endtask

  task automatic clr_pulse();
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.irq      = 1'b0;
    bus.readdata = '0;
    bus.pop      = 1'b0;
    bus.clr_ovf  = 1'b0;
    bus.irq_en   = 1'b1;
    repeat (3) tick();

    check("rst_count", 64'(bus.count), 0);
    check("rst_valid", 64'(bus.valid), 0);
    check("rst_full", 64'(bus.full), 0);
    check("rst_dout", bus.dout, 0);
    check("rst_ovf", 64'(bus.overflow), 0);
    check("rst_hirq", 64'(bus.host_irq), 0);
    rst_n = 1'b1;
    tick();

    // T1 capture, irq held 5 cycles
    bus.readdata = 64'hDEAD_BEEF_0000_00A5;
    bus.irq      = 1'b1;
    tick();
    check("t1_valid_first", 64'(bus.valid), 1);
    tick();
    check("t1_hirq", 64'(bus.host_irq), 1);
    repeat (3) tick();
    bus.irq = 1'b0;
    tick();
    check("t1_count", 64'(bus.count), 1);
    check("t1_dout", bus.dout, 64'hDEAD_BEEF_0000_00A5);
    pop_pulse();
    check("t1_drained", 64'(bus.count), 0);

    // T2 ordering
    push_ev(64'd1);
    push_ev(64'd2);
    push_ev(64'd3);
    check("t2_count3", 64'(bus.count), 3);
    for (int i = 1; i <= 3; i++) begin
      check("t2_head", bus.dout, 64'(i));
      pop_pulse();
    end
    check("t2_count0", 64'(bus.count), 0);
    check("t2_valid0", 64'(bus.valid), 0);
    check("t2_dout0", bus.dout, 0);
    tick();
    check("t2_hirq0", 64'(bus.host_irq), 0);

    // T3 overflow
    for (int i = 1; i <= 9; i++) push_ev(64'(i));
    check("t3_count", 64'(bus.count), 8);
    check("t3_full", 64'(bus.full), 1);
    check("t3_ovf", 64'(bus.overflow), 1);
    for (int i = 1; i <= 8; i++) begin
      check("t3_drain", bus.dout, 64'(i));
      pop_pulse();
    end
    check("t3_empty", 64'(bus.count), 0);
    clr_pulse();
    check("t3_clr", 64'(bus.overflow), 0);

    // T4 case A: full, push + pop same cycle
    for (int i = 10; i <= 17; i++) push_ev(64'(i));
    bus.readdata = 64'd99;
    bus.irq      = 1'b1;
    bus.pop      = 1'b1;
    tick();
    bus.irq = 1'b0;
    bus.pop = 1'b0;
    tick();
    check("t4a_count", 64'(bus.count), 8);
    check("t4a_ovf", 64'(bus.overflow), 0);
    check("t4a_head", bus.dout, 64'd11);
    for (int i = 11; i <= 17; i++) begin
      check("t4a_drain", bus.dout, 64'(i));
      pop_pulse();
    end
    check("t4a_tail", bus.dout, 64'd99);
    pop_pulse();

    // T4 case B: empty, push + pop same cycle
    bus.readdata = 64'd55;
    bus.irq      = 1'b1;
    bus.pop      = 1'b1;
    tick();
    bus.irq = 1'b0;
    bus.pop = 1'b0;
    tick();
    check("t4b_count", 64'(bus.count), 1);
    check("t4b_dout", bus.dout, 64'd55);
    pop_pulse();

    // T5 wrap
    for (int i = 0; i < 20; i++) begin
      push_ev(64'h1000 + 64'(i));
      check("t5_wrap", bus.dout, 64'h1000 + 64'(i));
      pop_pulse();
    end
    check("t5_wrap_empty", 64'(bus.count), 0);

    // T5 async reset with count=5 and overflow set
    for (int i = 0; i < 9; i++) push_ev(64'h2000 + 64'(i));
    repeat (3) pop_pulse();
    check("t5_pre_count", 64'(bus.count), 5);
    check("t5_pre_ovf", 64'(bus.overflow), 1);
    rst_n = 1'b0;
    #1;
    check("t5_async_count", 64'(bus.count), 0);
    check("t5_async_valid", 64'(bus.valid), 0);
    check("t5_async_ovf", 64'(bus.overflow), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // T6 pop level held 10 cycles
    for (int i = 0; i < 4; i++) push_ev(64'h3000 + 64'(i));
    check("t6_count4", 64'(bus.count), 4);
    bus.pop = 1'b1;
    repeat (10) tick();
    bus.pop = 1'b0;
    tick();
    check("t6_count3", 64'(bus.count), 3);
    check("t6_head", bus.dout, 64'h3001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
